// File: rtl/sync_fifo_cfg_if.sv
// Handshake/status bundle for sync_fifo_cfg: producer/consumer side is master,
// the FIFO itself is slave.
interface sync_fifo_cfg_if #(
  parameter int RW    = 64,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          wren;
  logic [RW-1:0] din;
  logic          rden;
  logic [RW-1:0] dout;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output flush, wren, din, rden,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, wren, din, rden,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO, any DEPTH >= 2, registered or fall-through read, programmable
// almost thresholds, occupancy count and sticky overflow/underflow flags.
module sync_fifo_cfg #(
  parameter int RW        = 64,
  parameter int DEPTH     = 64,
  parameter int FWFT      = 0,
  parameter int AE_THRESH = 1,
  parameter int AF_THRESH = 1
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_cfg_if.slave fif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_cfg: DEPTH must be >= 2");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_cfg: AE_THRESH must be < DEPTH");
  end
  if (AF_THRESH >= DEPTH) begin : g_bad_af
    $error("sync_fifo_cfg: AF_THRESH must be < DEPTH");
  end

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wrptr;
  logic [PW-1:0] rdptr;
  logic [PW-1:0] wrptr_nxt;
  logic [PW-1:0] rdptr_nxt;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          full_w;
  logic          empty_w;
  logic          wr_ok;
  logic          rd_ok;

  always_comb begin
    full_w    = (count_q == CW'(DEPTH));
    empty_w   = (count_q == '0);
    // flush discards both requests, so it gates acceptance directly
    wr_ok     = fif.wren && !full_w  && !fif.flush;
    rd_ok     = fif.rden && !empty_w && !fif.flush;
    wrptr_nxt = (wrptr == PW'(DEPTH - 1)) ? '0 : wrptr + PW'(1);
    rdptr_nxt = (rdptr == PW'(DEPTH - 1)) ? '0 : rdptr + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrptr       <= '0;
      rdptr       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (fif.flush) begin
      wrptr       <= '0;
      rdptr       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wrptr <= wrptr_nxt;
      if (rd_ok) rdptr <= rdptr_nxt;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (fif.wren && full_w)  overflow_q  <= 1'b1;
      if (fif.rden && empty_w) underflow_q <= 1'b1;
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wrptr] <= fif.din;
  end

  if (FWFT != 0) begin : g_fwft
    assign fif.dout = mem[rdptr];
  end else begin : g_reg
    logic [RW-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         dout_q <= '0;
      else if (fif.flush) dout_q <= '0;
      else if (rd_ok)     dout_q <= mem[rdptr];
    end
    assign fif.dout = dout_q;
  end

  assign fif.empty        = empty_w;
  assign fif.full         = full_w;
  assign fif.almost_empty = (count_q <= CW'(AE_THRESH));
  assign fif.almost_full  = (count_q >= CW'(DEPTH - AF_THRESH));
  assign fif.count        = count_q;
  assign fif.overflow     = overflow_q;
  assign fif.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Scoreboard bench for sync_fifo_cfg: three configurations (DEPTH=5 registered,
// DEPTH=4 fall-through, DEPTH=8 with wide thresholds) driven by directed vectors.
module tb_sync_fifo_cfg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sync_fifo_cfg_if #(.RW(8), .DEPTH(5)) f0 ();
  sync_fifo_cfg_if #(.RW(8), .DEPTH(4)) f1 ();
  sync_fifo_cfg_if #(.RW(8), .DEPTH(8)) f2 ();

  sync_fifo_cfg #(.RW(8), .DEPTH(5), .FWFT(0), .AE_THRESH(1), .AF_THRESH(1))
    u0 (.clk(clk), .rst_n(rst_n), .fif(f0));
  sync_fifo_cfg #(.RW(8), .DEPTH(4), .FWFT(1), .AE_THRESH(1), .AF_THRESH(1))
    u1 (.clk(clk), .rst_n(rst_n), .fif(f1));
  sync_fifo_cfg #(.RW(8), .DEPTH(8), .FWFT(0), .AE_THRESH(2), .AF_THRESH(3))
    u2 (.clk(clk), .rst_n(rst_n), .fif(f2));

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered-read monitors: a pop seen before an edge is checked on the next negedge.
  bit         pend0 = 0;
  bit         pend2 = 0;
  logic [7:0] e0, e1, e2;

  always @(negedge clk) begin
    if (pend0) begin
      pend0 = 0;
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL u0_unexpected_pop: got %0h expected none", f0.dout);
      end else begin
        e0 = q0.pop_front();
        chk("u0_dout", {24'd0, f0.dout}, {24'd0, e0});
      end
    end
    if (rst_n && f0.rden && !f0.empty && !f0.flush) pend0 = 1;
  end

  always @(negedge clk) begin
    if (pend2) begin
      pend2 = 0;
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL u2_unexpected_pop: got %0h expected none", f2.dout);
      end else begin
        e2 = q2.pop_front();
        chk("u2_dout", {24'd0, f2.dout}, {24'd0, e2});
      end
    end
    if (rst_n && f2.rden && !f2.empty && !f2.flush) pend2 = 1;
  end

  // Fall-through monitor: data must already be on dout when the pop is presented.
  always @(negedge clk) begin
    if (rst_n && f1.rden && !f1.empty && !f1.flush) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected_pop: got %0h expected none", f1.dout);
      end else begin
        e1 = q1.pop_front();
        chk("u1_dout", {24'd0, f1.dout}, {24'd0, e1});
      end
    end
  end

  task automatic op0(input bit w, input bit r, input logic [7:0] d, input bit fl = 0);
    f0.wren = w; f0.rden = r; f0.din = d; f0.flush = fl;
    @(posedge clk); #1;
    f0.wren = 0; f0.rden = 0; f0.flush = 0;
  endtask

  task automatic op1(input bit w, input bit r, input logic [7:0] d);
    f1.wren = w; f1.rden = r; f1.din = d;
    @(posedge clk); #1;
    f1.wren = 0; f1.rden = 0;
  endtask

  task automatic op2(input bit w, input bit r, input logic [7:0] d);
    f2.wren = w; f2.rden = r; f2.din = d;
    @(posedge clk); #1;
    f2.wren = 0; f2.rden = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    f0.wren = 0; f0.rden = 0; f0.din = '0; f0.flush = 0;
    f1.wren = 0; f1.rden = 0; f1.din = '0; f1.flush = 0;
    f2.wren = 0; f2.rden = 0; f2.din = '0; f2.flush = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    chk("rst_count", {29'd0, f0.count}, 0);
    chk("rst_empty", {31'd0, f0.empty}, 1);
    chk("rst_full",  {31'd0, f0.full}, 0);
    chk("rst_ae",    {31'd0, f0.almost_empty}, 1);
    chk("rst_af",    {31'd0, f0.almost_full}, 0);
    chk("rst_dout",  {24'd0, f0.dout}, 0);
    chk("rst_ov",    {31'd0, f0.overflow}, 0);
    chk("rst_un",    {31'd0, f0.underflow}, 0);
    chk("rst_af_u2", {31'd0, f2.almost_full}, 0);

    // Async reset mid-traffic at count=5 with non-zero dout
    op0(1, 0, 8'h11);
    q0.push_back(8'h11);
    op0(1, 1, 8'h12);
    op0(1, 0, 8'h13); op0(1, 0, 8'h14); op0(1, 0, 8'h15); op0(1, 0, 8'h16);
    chk("pre_rst_count", {29'd0, f0.count}, 5);
    chk("pre_rst_dout",  {24'd0, f0.dout}, 8'h11);
    f0.wren = 1; f0.din = 8'h17;
    #2 rst_n = 0;
    #1;
    chk("arst_count", {29'd0, f0.count}, 0);
    chk("arst_empty", {31'd0, f0.empty}, 1);
    chk("arst_full",  {31'd0, f0.full}, 0);
    chk("arst_dout",  {24'd0, f0.dout}, 0);
    chk("arst_ov",    {31'd0, f0.overflow}, 0);
    f0.wren = 0;
    #3 rst_n = 1;
    @(posedge clk); #1;

    // Fill/drain DEPTH=5 three passes, overflow attempt each pass
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 5; k++) op0(1, 0, 8'(p * 16 + k));
      chk("fill_count", {29'd0, f0.count}, 5);
      chk("fill_full",  {31'd0, f0.full}, 1);
      chk("fill_af",    {31'd0, f0.almost_full}, 1);
      chk("fill_un",    {31'd0, f0.underflow}, 0);
      op0(1, 0, 8'hEE);
      chk("ovf_flag",  {31'd0, f0.overflow}, 1);
      chk("ovf_count", {29'd0, f0.count}, 5);
      for (int k = 1; k <= 5; k++) begin
        q0.push_back(8'(p * 16 + k));
        op0(0, 1, 8'h00);
      end
      chk("drain_empty", {31'd0, f0.empty}, 1);
      chk("drain_count", {29'd0, f0.count}, 0);
    end
    op0(0, 1, 8'h00);
    chk("unf_flag",  {31'd0, f0.underflow}, 1);
    chk("unf_count", {29'd0, f0.count}, 0);
    op0(0, 0, 8'h00, 1);
    chk("flush_ov",   {31'd0, f0.overflow}, 0);
    chk("flush_un",   {31'd0, f0.underflow}, 0);
    chk("flush_dout", {24'd0, f0.dout}, 0);

    // Simultaneous wren+rden at count 0, 2, DEPTH
    op0(1, 1, 8'h31);
    chk("rw0_count", {29'd0, f0.count}, 1);
    chk("rw0_un",    {31'd0, f0.underflow}, 1);
    chk("rw0_ov",    {31'd0, f0.overflow}, 0);
    op0(0, 0, 8'h00, 1);
    op0(1, 0, 8'h41); op0(1, 0, 8'h42);
    q0.push_back(8'h41);
    op0(1, 1, 8'h43);
    chk("rw2_count", {29'd0, f0.count}, 2);
    chk("rw2_un",    {31'd0, f0.underflow}, 0);
    chk("rw2_ov",    {31'd0, f0.overflow}, 0);
    op0(1, 0, 8'h44); op0(1, 0, 8'h45); op0(1, 0, 8'h46);
    chk("rwf_full", {31'd0, f0.full}, 1);
    q0.push_back(8'h42);
    op0(1, 1, 8'h47);
    chk("rwf_count", {29'd0, f0.count}, 4);
    chk("rwf_ov",    {31'd0, f0.overflow}, 1);
    chk("rwf_un",    {31'd0, f0.underflow}, 0);
    for (int k = 3; k <= 6; k++) begin
      q0.push_back(8'(8'h40 + k));
      op0(0, 1, 8'h00);
    end
    chk("rwf_empty", {31'd0, f0.empty}, 1);

    // flush with wren+rden at count=3 and overflow set
    op0(1, 0, 8'h51); op0(1, 0, 8'h52); op0(1, 0, 8'h53);
    chk("pfl_count", {29'd0, f0.count}, 3);
    chk("pfl_ov",    {31'd0, f0.overflow}, 1);
    op0(1, 1, 8'h5F, 1);
    chk("fl_count", {29'd0, f0.count}, 0);
    chk("fl_empty", {31'd0, f0.empty}, 1);
    chk("fl_ov",    {31'd0, f0.overflow}, 0);
    chk("fl_un",    {31'd0, f0.underflow}, 0);
    chk("fl_dout",  {24'd0, f0.dout}, 0);
    op0(1, 0, 8'h61);
    chk("pfw_count", {29'd0, f0.count}, 1);
    q0.push_back(8'h61);
    op0(0, 1, 8'h00);
    chk("pfr_empty", {31'd0, f0.empty}, 1);

    // FWFT DEPTH=4
    op1(1, 0, 8'h0A);
    chk("fw_empty", {31'd0, f1.empty}, 0);
    chk("fw_dout",  {24'd0, f1.dout}, 8'h0A);
    op1(1, 0, 8'h0B);
    q1.push_back(8'h0A);
    op1(0, 1, 8'h00);
    chk("fw_next",  {24'd0, f1.dout}, 8'h0B);
    chk("fw_count", {29'd0, f1.count}, 1);
    q1.push_back(8'h0B);
    op1(0, 1, 8'h00);
    chk("fw_empty2", {31'd0, f1.empty}, 1);
    for (int k = 0; k < 4; k++) op1(1, 0, 8'(8'h0C + k));
    chk("fw_full", {31'd0, f1.full}, 1);
    for (int k = 0; k < 4; k++) begin
      q1.push_back(8'(8'h0C + k));
      op1(0, 1, 8'h00);
    end
    chk("fw_empty3", {31'd0, f1.empty}, 1);

    // Thresholds DEPTH=8, AE=2, AF=3
    chk("th_ae0", {31'd0, f2.almost_empty}, 1);
    for (int c = 1; c <= 8; c++) begin
      op2(1, 0, 8'(c));
      chk("th_up_count", {28'd0, f2.count}, 32'(c));
      chk("th_up_ae", {31'd0, f2.almost_empty}, (c <= 2) ? 1 : 0);
      chk("th_up_af", {31'd0, f2.almost_full}, (c >= 5) ? 1 : 0);
    end
    for (int i = 1; i <= 8; i++) begin
      q2.push_back(8'(i));
      op2(0, 1, 8'h00);
      chk("th_dn_count", {28'd0, f2.count}, 32'(8 - i));
      chk("th_dn_ae", {31'd0, f2.almost_empty}, ((8 - i) <= 2) ? 1 : 0);
      chk("th_dn_af", {31'd0, f2.almost_full}, ((8 - i) >= 5) ? 1 : 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
